// File: rtl/spike_serializer.sv
// Word-to-bit serializer driving a four-phase return-to-zero req/ack channel.
// The returned ack is synchronised locally and a watchdog traps stalled handshakes.
module spike_serializer #(
    parameter int DATA_BITS      = 4,
    parameter int SETUP_CYCLES   = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    output logic                 data_out,
    output logic                 req_out,
    input  logic                 ack_out,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam int SC_W = (SETUP_CYCLES < 2) ? 1 : $clog2(SETUP_CYCLES);
    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO,
        FAULT
    } state_t;

    state_t               state_reg, state_next;
    logic [DATA_BITS-1:0] shreg_reg, shreg_next;
    logic [BC_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [SC_W-1:0]      setup_cnt_reg, setup_cnt_next;
    logic [WD_W-1:0]      wd_reg, wd_next;
    logic                 data_reg, data_next;
    logic                 req_reg, req_next;
    logic                 ready_reg, ready_next;
    logic                 busy_reg, busy_next;
    logic                 err_reg, err_next;
    logic [SYNC_STAGES-1:0] sync_reg;

    logic                 ack_s;
    logic                 first_bit;
    logic                 next_bit;
    logic [DATA_BITS-1:0] shifted;
    logic [WD_W-1:0]      wd_inc;
    logic                 wd_expired;
    logic                 fault_now;

    assign ack_s = sync_reg[SYNC_STAGES-1];

    // Bit order only changes which end of the shift register feeds data_out.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign first_bit = word_in[DATA_BITS-1];
        assign shifted   = shreg_reg << 1;
        assign next_bit  = shifted[DATA_BITS-1];
    end else begin : g_lsb_first
        assign first_bit = word_in[0];
        assign shifted   = shreg_reg >> 1;
        assign next_bit  = shifted[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ack_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            bit_cnt_reg   <= '0;
            setup_cnt_reg <= '0;
            wd_reg        <= '0;
            data_reg      <= 1'b0;
            req_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            bit_cnt_reg   <= bit_cnt_next;
            setup_cnt_reg <= setup_cnt_next;
            wd_reg        <= wd_next;
            data_reg      <= data_next;
            req_reg       <= req_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        bit_cnt_next   = bit_cnt_reg;
        setup_cnt_next = setup_cnt_reg;
        wd_next        = wd_reg;
        data_next      = data_reg;
        req_next       = req_reg;
        err_next       = err_reg;
        fault_now      = 1'b0;
        wd_inc         = wd_reg + 1'b1;
        wd_expired     = (TIMEOUT_CYCLES != 0) && (wd_inc == WD_W'(TIMEOUT_CYCLES));

        case (state_reg)
            IDLE: begin
                req_next  = 1'b0;
                data_next = 1'b0;
                if (word_valid && ready_reg) begin
                    shreg_next     = word_in;
                    bit_cnt_next   = BC_W'(DATA_BITS);
                    setup_cnt_next = '0;
                    data_next      = first_bit;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_reg == SC_W'(SETUP_CYCLES - 1)) begin
                    req_next   = 1'b1;
                    wd_next    = '0;
                    state_next = REQ_HI;
                end else begin
                    setup_cnt_next = setup_cnt_reg + 1'b1;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_next   = 1'b0;
                    wd_next    = '0;
                    state_next = REQ_LO;
                end else if (wd_expired) begin
                    fault_now = 1'b1;
                end else begin
                    wd_next = wd_inc;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                    if (bit_cnt_reg == BC_W'(1)) begin
                        data_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        // Safe to move data here: both req and synchronised ack are low.
                        shreg_next     = shifted;
                        data_next      = next_bit;
                        setup_cnt_next = '0;
                        state_next     = SETUP;
                    end
                end else if (wd_expired) begin
                    fault_now = 1'b1;
                end else begin
                    wd_next = wd_inc;
                end
            end
            FAULT: begin
                if (err_clr) begin
                    err_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A stalled handshake abandons the word and parks until err_clr.
        if (fault_now) begin
            state_next   = FAULT;
            req_next     = 1'b0;
            data_next    = 1'b0;
            err_next     = 1'b1;
            shreg_next   = '0;
            bit_cnt_next = '0;
        end

        ready_next = (state_next == IDLE);
        busy_next  = (state_next != IDLE);
    end

    assign word_ready  = ready_reg;
    assign data_out    = data_reg;
    assign req_out     = req_reg;
    assign busy        = busy_reg;
    assign timeout_err = err_reg;

endmodule

// File: tb/tb_spike_serializer.sv
// Directed bench for spike_serializer: default, LSB-first and short-timeout instances
// with behavioural neuron ack models.
module tb_spike_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] word_in0, word_in1, word_in2;
    logic       valid0, valid1, valid2;
    logic       ready0, ready1, ready2;
    logic       data0, data1, data2;
    logic       req0, req1, req2;
    logic       ack0, ack1, ack2;
    logic       clr0, clr1, clr2;
    logic       busy0, busy1, busy2;
    logic       terr0, terr1, terr2;

    int          ack_dly0 = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] bits0 = '0;
    logic [31:0] bits1 = '0;
    int          cnt0 = 0;
    int          cnt1 = 0;
    int          viol0 = 0;
    logic        p_req0 = 1'b0;
    logic        p_ack0 = 1'b0;
    logic        p_data0 = 1'b0;
    logic        p_req1 = 1'b0;

    typedef struct {
        int         dut;
        logic [3:0] word;
        logic [3:0] exp_bits;
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    spike_serializer dut0 (
        .clk(clk), .rst(rst), .word_in(word_in0), .word_valid(valid0), .word_ready(ready0),
        .data_out(data0), .req_out(req0), .ack_out(ack0), .err_clr(clr0), .busy(busy0),
        .timeout_err(terr0)
    );

    spike_serializer #(.MSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .word_in(word_in1), .word_valid(valid1), .word_ready(ready1),
        .data_out(data1), .req_out(req1), .ack_out(ack1), .err_clr(clr1), .busy(busy1),
        .timeout_err(terr1)
    );

    spike_serializer #(.TIMEOUT_CYCLES(10)) dut2 (
        .clk(clk), .rst(rst), .word_in(word_in2), .word_valid(valid2), .word_ready(ready2),
        .data_out(data2), .req_out(req2), .ack_out(ack2), .err_clr(clr2), .busy(busy2),
        .timeout_err(terr2)
    );

    // Neuron ack models: echo req shortly after it moves, optionally ack_dly0 cycles later.
    always begin
        @(req0);
        if (ack_dly0 > 0) repeat (ack_dly0) @(posedge clk);
        #1 ack0 = req0;
    end

    always begin
        @(req1);
        #1 ack1 = req1;
    end

    always @(negedge clk) begin
        if (req0 === 1'b1 && p_req0 === 1'b0) begin
            bits0 <= {bits0[30:0], data0};
            cnt0  <= cnt0 + 1;
        end
        if (!rst && (data0 !== p_data0) && (p_req0 || p_ack0 || req0 || ack0)) begin
            viol0 <= viol0 + 1;
        end
        p_req0  <= req0;
        p_ack0  <= ack0;
        p_data0 <= data0;
    end

    always @(negedge clk) begin
        if (req1 === 1'b1 && p_req1 === 1'b0) begin
            bits1 <= {bits1[30:0], data1};
            cnt1  <= cnt1 + 1;
        end
        p_req1 <= req1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Offer one word, wait for acceptance, then count the cycles busy stays high.
    task automatic send_word(input int d, input logic [3:0] w, output int bcyc);
        int n;
        if (d == 0) begin
            word_in0 = w;
            valid0   = 1'b1;
        end else begin
            word_in1 = w;
            valid1   = 1'b1;
        end
        n = 0;
        while (((d == 0) ? busy0 : busy1) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        bcyc = 0;
        while (((d == 0) ? busy0 : busy1) === 1'b1 && bcyc < 5000) begin
            @(negedge clk);
            bcyc++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: still running at 500000 ns, limit 500000 ns");
        $fatal(1);
    end

    initial begin
        int bcyc;
        int n;
        int c_before;
        int c_after;
        logic [31:0] b;

        vecs[0] = '{0, 4'b1011, 4'b1011, 28};
        vecs[1] = '{0, 4'hA,    4'b1010, 28};
        vecs[2] = '{0, 4'h0,    4'b0000, 28};
        vecs[3] = '{1, 4'b1000, 4'b0001, 28};
        vecs[4] = '{1, 4'b0110, 4'b0110, 28};
        vecs[5] = '{1, 4'b1101, 4'b1011, 28};

        rst = 1'b1;
        word_in0 = '0; word_in1 = '0; word_in2 = '0;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
        ack0 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_data_out", data0, 1'b0);
        check("rst_req_out", req0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_timeout_err", terr0, 1'b0);
        check("rst_word_ready", ready0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release_0", ready0, 1'b1);
        check("ready_after_release_1", ready1, 1'b1);
        check("ready_after_release_2", ready2, 1'b1);

        for (int i = 0; i < 6; i++) begin
            c_before = (vecs[i].dut == 0) ? cnt0 : cnt1;
            send_word(vecs[i].dut, vecs[i].word, bcyc);
            c_after = (vecs[i].dut == 0) ? cnt0 : cnt1;
            b = (vecs[i].dut == 0) ? bits0 : bits1;
            check($sformatf("vec%0d_handshakes", i), c_after - c_before, 4);
            check($sformatf("vec%0d_bits", i), b[3:0], vecs[i].exp_bits);
            check($sformatf("vec%0d_busy_cycles", i), bcyc, vecs[i].exp_busy);
            check($sformatf("vec%0d_ready_after", i),
                  (vecs[i].dut == 0) ? ready0 : ready1, 1'b1);
        end

        // Back-to-back: valid held high, second word must go in right after the first.
        c_before = cnt0;
        word_in0 = 4'hA;
        valid0   = 1'b1;
        n = 0;
        while (busy0 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        word_in0 = 4'h5;
        n = 0;
        while (busy0 === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_busy_cycles", n, 28);
        @(negedge clk);
        check("b2b_second_accepted_next_cycle", busy0, 1'b1);
        valid0 = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_busy_cycles", n, 28);
        check("b2b_handshakes", cnt0 - c_before, 8);
        check("b2b_bits", bits0[7:0], 8'hA5);
        check("b2b_data_stability_violations", viol0, 0);

        // Slow neuron: each ack edge 20 cycles late, 1 + 2*(20+3) cycles per bit.
        ack_dly0 = 20;
        c_before = cnt0;
        send_word(0, 4'b0110, bcyc);
        check("slow_busy_cycles", bcyc, 188);
        check("slow_handshakes", cnt0 - c_before, 4);
        check("slow_bits", bits0[3:0], 4'b0110);
        check("slow_no_timeout", terr0, 1'b0);
        check("slow_ready_after", ready0, 1'b1);
        ack_dly0 = 0;

        // Timeout with ack stuck low on the TIMEOUT_CYCLES=10 instance.
        word_in2 = 4'b1011;
        valid2   = 1'b1;
        n = 0;
        while (busy2 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        valid2 = 1'b0;
        n = 0;
        while (req2 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_first_bit_on_req", data2, 1'b1);
        n = 0;
        while (terr2 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles_after_req_hi", n, 10);
        check("to_req_dropped", req2, 1'b0);
        check("to_data_cleared", data2, 1'b0);
        check("to_busy_in_fault", busy2, 1'b1);
        repeat (5) @(negedge clk);
        check("to_ready_held_low", ready2, 1'b0);
        check("to_err_sticky", terr2, 1'b1);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        check("to_err_cleared", terr2, 1'b0);
        check("to_ready_after_clr", ready2, 1'b1);
        check("to_busy_after_clr", busy2, 1'b0);

        // Reset in the middle of a handshake, then a clean word afterwards.
        word_in0 = 4'hF;
        valid0   = 1'b1;
        n = 0;
        while (req0 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        valid0 = 1'b0;
        check("midrst_req_seen_before_reset", req0, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_data_out", data0, 1'b0);
        check("midrst_req_out", req0, 1'b0);
        check("midrst_busy", busy0, 1'b0);
        check("midrst_timeout_err", terr0, 1'b0);
        check("midrst_ready_low", ready0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after_release", ready0, 1'b1);
        c_before = cnt0;
        send_word(0, 4'b1001, bcyc);
        check("midrst_recover_busy_cycles", bcyc, 28);
        check("midrst_recover_handshakes", cnt0 - c_before, 4);
        check("midrst_recover_bits", bits0[3:0], 4'b1001);

        check("final_data_stability_violations", viol0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_serializer.md
Name: spike_serializer

Overview:
- Upstream feeder for the neuron block.
- Accepts a DATA_BITS-wide word from a clocked producer over a valid/ready interface.
- Shifts the word out one bit at a time on a four-phase return-to-zero req/ack channel that connects directly to the neuron's data_in/req_in/ack_in.
- The ack returned by the neuron is asynchronous, so it is synchronised internally. A watchdog flags a stalled handshake.

Parameters:
- DATA_BITS, 4: word width; number of handshakes per word.
- SETUP_CYCLES, 1: cycles data_out is held stable before req_out rises (legal range ≥1).
- SYNC_STAGES, 2: flops in the ack_out synchroniser (legal range ≥2).
- MSB_FIRST, 1: 1 = bit DATA_BITS-1 is sent first; 0 = bit 0 is sent first.
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for one ack edge; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- word_in  in  DATA_BITS  word to serialise.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  block can accept a word.
- data_out  out  1  serial bit to the neuron's data_in.
- req_out  out  1  request to the neuron's req_in.
- ack_out  in  1  asynchronous acknowledge from the neuron's ack_in.
- err_clr  in  1  clears the FAULT state and timeout_err.
- busy  out  1  a word is in flight.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - data_out=0, req_out=0, word_ready=0, busy=0, timeout_err=0.
  - Synchroniser flops, shift register, bit counter and watchdog are cleared.
  - State goes to IDLE; word_ready=1 from the first edge with rst=0.
- ack_s denotes ack_out after SYNC_STAGES flops. All FSM decisions use ack_s only.
- FSM states: IDLE, SETUP, REQ_HI, REQ_LO, FAULT.
- IDLE:
  - word_ready=1, busy=0, req_out=0, data_out=0.
  - On word_valid&&word_ready: load the shift register, set bit counter to DATA_BITS, drive data_out with the first bit, go to SETUP.
- SETUP:
  - Hold data_out; count SETUP_CYCLES cycles.
  - Then set req_out=1 and go to REQ_HI.
- REQ_HI:
  - Wait for ack_s=1, then set req_out=0 and go to REQ_LO.
- REQ_LO:
  - Wait for ack_s=0, then decrement the bit counter.
  - If the counter was 1: data_out=0, go to IDLE.
  - Otherwise: shift, present the next bit on data_out, go to SETUP.
- Stability rule: data_out changes only while req_out=0 and ack_s=0. It is stable from SETUP entry until ack_s falls in REQ_LO.
- Watchdog:
  - The counter resets on every entry to REQ_HI or REQ_LO and increments each cycle spent in those states.
  - When it reaches TIMEOUT_CYCLES (if nonzero): timeout_err=1, req_out=0, data_out=0, go to FAULT; the word is discarded.
- FAULT:
  - word_ready=0, busy=1.
  - err_clr=1 → IDLE, timeout_err=0 on the same edge.
  - err_clr outside FAULT has no effect.
- busy=1 in SETUP, REQ_HI, REQ_LO and FAULT.
- Ack polarity violations are not checked:
  - ack_s already high when entering REQ_HI completes that phase on the next edge.
  - ack_s glitches in SETUP are ignored.
- word_valid outside IDLE is ignored; the producer must hold the word until word_ready.
- Reset mid-handshake:
  - req_out drops on the reset edge and the current word is lost.
  - Neuron recovery is the system's responsibility; the neuron shares rst.
- Per-bit time with an ideal ack (the neuron answers a req/ack edge within one cycle):
  - SETUP_CYCLES + 2×(SYNC_STAGES+1) cycles.
  - For the defaults this is 7 cycles per bit and 28 cycles per word.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream → data_out=0, req_out=0, busy=0, timeout_err=0; word_ready=1 one cycle after release.
- Basic word:
  - Stimulus: defaults, word_in=4'b1011, ack model echoes req after 1 cycle.
  - Required: 4 req pulses with data_out=1,0,1,1 sampled at each req rise.
  - Required: busy high for 28 cycles, then word_ready=1.
- LSB first: MSB_FIRST=0, word_in=4'b1000 → data_out sequence 0,0,0,1.
- Back-to-back:
  - Stimulus: word_valid held with words 4'hA then 4'h5.
  - Required: second word accepted the cycle after the first completes; 8 handshakes in total.
  - Required: data_out never changes while req_out or ack_out is high.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=10, ack_out stuck at 0.
  - Required: timeout_err=1 and req_out=0 exactly 10 cycles after REQ_HI entry.
  - Required: word_ready stays 0 until err_clr pulse; timeout_err=0 and word_ready=1 after it.
- Slow ack: ack model delays each edge by 20 cycles with TIMEOUT_CYCLES=255 → word completes correctly with no error.
